// File: rtl/gpl_status_filter.sv
// GPL status line conditioner: 2-FF synchronizer, stable-level debounce FSM,
// registered edge pulses and a saturating counter of rejected transitions.
`timescale 1ns/1ps

// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | filter disabled, gpl_status held low
// LOW      | accepted level 0, watching for a 1
// RISE_CHK | synced input is 1, counting stable cycles before accepting
// HIGH     | accepted level 1, watching for a 0
// FALL_CHK | synced input is 0, counting stable cycles before accepting
module gpl_status_filter #(
    parameter int DEB_LEN = 100,
    parameter int CNT_W   = 12,
    parameter int GLT_W   = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             ena,
    input  logic             gpl_raw,
    input  logic             clr_cnt,
    output logic             gpl_status,
    output logic             gpl_rise,
    output logic             gpl_fall,
    output logic [GLT_W-1:0] glitch_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOW      = 3'd1,
        RISE_CHK = 3'd2,
        HIGH     = 3'd3,
        FALL_CHK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GLT_W-1:0] GLT_ONE  = GLT_W'(1);
    localparam logic [GLT_W-1:0] GLT_MAX  = '1;

    state_t           state;
    logic [CNT_W-1:0] deb_cnt;
    logic             sync_s1;
    logic             sync_s2;
    logic             glt_inc;

    // Synchronizer keeps running while disabled so re-enable sees a settled level.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= gpl_raw;
            sync_s2 <= sync_s1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            gpl_status <= 1'b0;
            gpl_rise   <= 1'b0;
            gpl_fall   <= 1'b0;
        end else begin
            gpl_rise <= 1'b0;
            gpl_fall <= 1'b0;
            if (!ena) begin
                // Disabling drops the level silently: no gpl_fall even from HIGH.
                state      <= IDLE;
                deb_cnt    <= '0;
                gpl_status <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= LOW;
                        deb_cnt    <= '0;
                        gpl_status <= 1'b0;
                    end
                    LOW: begin
                        gpl_status <= 1'b0;
                        if (sync_s2) begin
                            state   <= RISE_CHK;
                            deb_cnt <= '0;
                        end
                    end
                    RISE_CHK: begin
                        if (!sync_s2) begin
                            state <= LOW;
                        end else if (deb_cnt == DEB_LAST) begin
                            state      <= HIGH;
                            gpl_status <= 1'b1;
                            gpl_rise   <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + CNT_ONE;
                        end
                    end
                    HIGH: begin
                        gpl_status <= 1'b1;
                        if (!sync_s2) begin
                            state   <= FALL_CHK;
                            deb_cnt <= '0;
                        end
                    end
                    FALL_CHK: begin
                        if (sync_s2) begin
                            state <= HIGH;
                        end else if (deb_cnt == DEB_LAST) begin
                            state      <= LOW;
                            gpl_status <= 1'b0;
                            gpl_fall   <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        deb_cnt    <= '0;
                        gpl_status <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A reversion during a check is a rejected transition.
    always_comb begin
        glt_inc = 1'b0;
        if (ena) begin
            glt_inc = ((state == RISE_CHK) && !sync_s2) ||
                      ((state == FALL_CHK) &&  sync_s2);
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            glitch_cnt <= '0;
        end else if (clr_cnt) begin
            glitch_cnt <= '0;
        end else if (glt_inc && (glitch_cnt != GLT_MAX)) begin
            glitch_cnt <= glitch_cnt + GLT_ONE;
        end
    end

endmodule

// File: tb/tb_gpl_status_filter.sv
// Bench for gpl_status_filter: two instances (DEB_LEN=100 and DEB_LEN=1), directed
// scenarios with hand-derived edge counts, and a per-cycle scoreboard fed by a reference model.
`timescale 1ns/1ps

module tb_gpl_status_filter;

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_LOW  = 3'd1;
    localparam logic [2:0] M_RCHK = 3'd2;
    localparam logic [2:0] M_HIGH = 3'd3;
    localparam logic [2:0] M_FCHK = 3'd4;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] cnt;
        logic        s1;
        logic        s2;
        logic        status;
        logic        rise;
        logic        fall;
        logic [7:0]  glt;
    } mstate_t;

    typedef struct packed {
        logic       st0;
        logic       r0;
        logic       f0;
        logic [7:0] g0;
        logic       st1;
        logic       r1;
        logic       f1;
        logic [7:0] g1;
    } obs_t;

    logic       clk;
    logic       arst;
    logic       ena;
    logic       gpl_raw;
    logic       raw1;
    logic       clr_cnt;
    logic       status0, rise0, fall0;
    logic [7:0] glt0;
    logic       status1, rise1, fall1;
    logic [7:0] glt1;

    logic arst_r, ena_r, raw_r, raw1_r, clr_r;
    mstate_t m0, m1;
    obs_t exp_q[$];
    int n_vec;
    int n_miss;

    gpl_status_filter #(.DEB_LEN(100), .CNT_W(12), .GLT_W(8)) u_dut (
        .clk(clk), .arst(arst), .ena(ena), .gpl_raw(gpl_raw), .clr_cnt(clr_cnt),
        .gpl_status(status0), .gpl_rise(rise0), .gpl_fall(fall0), .glitch_cnt(glt0)
    );

    gpl_status_filter #(.DEB_LEN(1), .CNT_W(12), .GLT_W(8)) u_one (
        .clk(clk), .arst(arst), .ena(ena), .gpl_raw(raw1), .clr_cnt(clr_cnt),
        .gpl_status(status1), .gpl_rise(rise1), .gpl_fall(fall1), .glitch_cnt(glt1)
    );

    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    function automatic mstate_t model_step(mstate_t m, int deb_len, logic a, logic e,
                                           logic r, logic c);
        mstate_t n;
        logic    inc;
        n      = m;
        inc    = 1'b0;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (a) begin
            n = '0;
            return n;
        end
        n.s1 = r;
        n.s2 = m.s1;
        if (!e) begin
            n.st     = M_IDLE;
            n.cnt    = '0;
            n.status = 1'b0;
        end else begin
            case (m.st)
                M_IDLE: begin
                    n.st = M_LOW; n.cnt = '0; n.status = 1'b0;
                end
                M_LOW: begin
                    n.status = 1'b0;
                    if (m.s2) begin n.st = M_RCHK; n.cnt = '0; end
                end
                M_RCHK: begin
                    if (!m.s2) begin
                        n.st = M_LOW; inc = 1'b1;
                    end else if (int'(m.cnt) == deb_len - 1) begin
                        n.st = M_HIGH; n.status = 1'b1; n.rise = 1'b1;
                    end else begin
                        n.cnt = m.cnt + 12'd1;
                    end
                end
                M_HIGH: begin
                    n.status = 1'b1;
                    if (!m.s2) begin n.st = M_FCHK; n.cnt = '0; end
                end
                M_FCHK: begin
                    if (m.s2) begin
                        n.st = M_HIGH; inc = 1'b1;
                    end else if (int'(m.cnt) == deb_len - 1) begin
                        n.st = M_LOW; n.status = 1'b0; n.fall = 1'b1;
                    end else begin
                        n.cnt = m.cnt + 12'd1;
                    end
                end
                default: begin
                    n.st = M_IDLE; n.cnt = '0; n.status = 1'b0;
                end
            endcase
        end
        if (c) n.glt = 8'd0;
        else if (inc && (m.glt != 8'hFF)) n.glt = m.glt + 8'd1;
        return n;
    endfunction

    // One clock: drive at negedge, predict the post-edge outputs, return #1 after posedge.
    task automatic cyc();
        obs_t e;
        @(negedge clk);
        arst    = arst_r;
        ena     = ena_r;
        gpl_raw = raw_r;
        raw1    = raw1_r;
        clr_cnt = clr_r;
        m0 = model_step(m0, 100, arst_r, ena_r, raw_r, clr_r);
        m1 = model_step(m1, 1, arst_r, ena_r, raw1_r, clr_r);
        e  = {m0.status, m0.rise, m0.fall, m0.glt, m1.status, m1.rise, m1.fall, m1.glt};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every edge that has a prediction is compared.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {status0, rise0, fall0, glt0, status1, rise1, fall1, glt1};
                n_vec++;
                if (a !== e) begin
                    n_miss++;
                    $display("FAIL cycle_check @%0t: got %h expected %h", $time, a, e);
                end
            end
        end
    end

    initial begin
        int n;
        int cnt_r;
        int cnt_f;
        bit seen;
        n_vec  = 0;
        n_miss = 0;
        m0 = '0;
        m1 = '0;
        arst = 1'b1; ena = 1'b1; gpl_raw = 1'b1; raw1 = 1'b0; clr_cnt = 1'b0;
        arst_r = 1'b1; ena_r = 1'b1; raw_r = 1'b1; raw1_r = 1'b0; clr_r = 1'b0;

        // Reset held with raw high and enabled: everything stays zero.
        repeat (3) cyc();
        chk("reset_out", int'({status0, rise0, fall0, glt0}), 0);

        // First accepted rise lands on edge DEB_LEN+3 after release.
        arst_r = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc(); n++;
            if (rise0) seen = 1;
        end
        chk("rise_edge", seen ? n : -1, 103);
        chk("status_after_rise", int'(status0), 1);
        cyc();
        chk("rise_width", int'(rise0), 0);

        // Held low: fall on edge 103, one cycle wide.
        raw_r = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc(); n++;
            if (fall0) seen = 1;
        end
        chk("fall_edge", seen ? n : -1, 103);
        chk("status_after_fall", int'(status0), 0);
        cyc();
        chk("fall_width", int'(fall0), 0);

        // 50-cycle high pulse is rejected and counted.
        raw_r = 1'b1;
        cnt_r = 0;
        repeat (50) begin cyc(); if (rise0) cnt_r++; end
        raw_r = 1'b0;
        repeat (20) begin cyc(); if (rise0) cnt_r++; end
        chk("short_pulse_rises", cnt_r, 0);
        chk("short_pulse_status", int'(status0), 0);
        chk("short_pulse_glt", int'(glt0), 1);

        // Saturation, plain clear, clear coincident with an increment.
        clr_r = 1'b1; cyc(); clr_r = 1'b0;
        chk("clr_plain_a", int'(glt0), 0);
        for (int g = 0; g < 300; g++) begin
            raw_r = 1'b1; repeat (10) cyc();
            raw_r = 1'b0; repeat (10) cyc();
        end
        chk("glt_saturate", int'(glt0), 255);
        clr_r = 1'b1; cyc(); clr_r = 1'b0;
        chk("clr_plain_b", int'(glt0), 0);
        raw_r = 1'b1; repeat (10) cyc();
        raw_r = 1'b0; cyc(); cyc();
        clr_r = 1'b1; cyc(); clr_r = 1'b0;   // edge 13: reversion seen here
        chk("clr_wins", int'(glt0), 0);
        raw_r = 1'b1; repeat (10) cyc();
        raw_r = 1'b0; repeat (10) cyc();
        chk("glt_after_clr", int'(glt0), 1);

        // Enable drop from HIGH: silent drop, then IDLE->LOW->RISE_CHK re-qualify.
        raw_r = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc();
            if (status0) seen = 1;
        end
        chk("reach_high", int'(seen), 1);
        repeat (3) cyc();
        ena_r = 1'b0; cnt_f = 0;
        cyc();
        if (fall0) cnt_f++;
        chk("ena_drop_status", int'(status0), 0);
        ena_r = 1'b1;
        n = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cyc(); n++;
            if (fall0) cnt_f++;
            if (status0) seen = 1;
        end
        chk("ena_drop_no_fall", cnt_f, 0);
        chk("ena_return_edge", seen ? n : -1, 102);

        // Async reset in the middle of a fall check clears outputs without a clock.
        raw_r = 1'b0;
        repeat (40) cyc();
        chk("mid_fchk_status", int'(status0), 1);
        @(negedge clk);
        arst_r = 1'b1;
        arst = 1'b1;
        #1;
        chk("arst_async", int'({status0, rise0, fall0, glt0}), 0);
        cyc();
        arst_r = 1'b0;
        repeat (5) cyc();

        // DEB_LEN=1: held high is accepted on edge 4.
        raw1_r = 1'b0;
        repeat (6) cyc();
        raw1_r = 1'b1;
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(); n++;
            if (status1) seen = 1;
        end
        chk("deb1_edge", seen ? n : -1, 4);

        // Random traffic on both instances, checked by the scoreboard each cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) raw_r = ~raw_r;
            if ($urandom_range(0, 2) == 0) raw1_r = ~raw1_r;
            ena_r = ($urandom_range(0, 199) != 0);
            clr_r = ($urandom_range(0, 99) == 0);
            cyc();
        end
        clr_r = 1'b0;
        ena_r = 1'b1;

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
